wb_write_buf: RTL and testbench

- Write-side front end for the general register file's single write port.
- Merges single-cycle writebacks from the MEM/WB pipeline register with late results from multi-cycle units (divider, uncached load return).
- Late results are buffered in a small in-order queue and drained into idle write-port cycles.
- Gives decode a bypass lookup into queued results, so pending values can be forwarded or stalled on.

---
 rtl/wb_write_buf_pkg.sv | 13 +
 rtl/wb_write_buf_if.sv | 49 ++++
 rtl/wb_write_buf_match.sv | 36 +++
 rtl/wb_write_buf.sv | 119 +++++++++++
 tb/tb_wb_write_buf.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_buf_pkg.sv
// Shared sizes and constants for the register-file write buffer.
// Imported by the interface, the match unit and the top.
package wb_write_buf_pkg;
  localparam int WBQ_DEPTH = 4;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic RST_EN = 1'b1;
  localparam logic WR_EN = 1'b1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_write_buf_if.sv
// Write-buffer bundle: pipe writeback, late-write handshake,
// register-file write port and the two decode bypass lookups.
interface wb_write_buf_if
  import wb_write_buf_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);
  localparam int CW = cnt_w(DEPTH);

  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          lw_valid;
  logic          lw_ready;
  logic [AW-1:0] lw_waddr;
  logic [DW-1:0] lw_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic          hit1;
  logic [DW-1:0] hdata1;
  logic [AW-1:0] raddr2;
  logic          hit2;
  logic [DW-1:0] hdata2;
  logic [CW-1:0] count;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lw_valid, lw_waddr, lw_wdata,
    output lw_ready,
    output we, waddr, wdata,
    input  raddr1, raddr2,
    output hit1, hdata1, hit2, hdata2,
    output count
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lw_valid, lw_waddr, lw_wdata,
    input  lw_ready,
    input  we, waddr, wdata,
    output raddr1, raddr2,
    input  hit1, hdata1, hit2, hdata2,
    input  count
  );
endinterface

// File: rtl/wb_write_buf_match.sv
// Bypass lookup: youngest valid queued entry matching raddr.
// Only live entries carry valid=1, so age follows from rd_ptr.
module wbq_match
  import wb_write_buf_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic [AW-1:0]                raddr,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0][AW-1:0]     addr,
  input  logic [DEPTH-1:0][DW-1:0]     data,
  output logic                         hit,
  output logic [DW-1:0]                hdata
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    hdata = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (vld[idx] && addr[idx] == raddr &&
          raddr != '0) begin
        hit = 1'b1;
        hdata = data[idx];
      end
    end
  end
endmodule

// File: rtl/wb_write_buf.sv
// Register-file write front end: pipe writes win, late results
// queue in order and drain into idle write-port cycles.
module wb_write_buf
  import wb_write_buf_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input logic         clk,
  input logic         rst,
  wb_write_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            cnt;
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;

  logic pipe_wr;
  logic has;
  logic pop;
  logic ready;
  logic acc;
  logic push;
  logic lw_kill;

  assign pipe_wr = bus.pipe_we &&
                   bus.pipe_waddr != '0;
  assign has = cnt != '0;
  assign pop = has && !pipe_wr;
  assign ready = (rst != RST_EN) &&
                 (cnt < CW'(DEPTH));
  assign acc = bus.lw_valid && ready;
  assign push = acc && bus.lw_waddr != '0;
  assign lw_kill = pipe_wr &&
                   bus.lw_waddr == bus.pipe_waddr;

  assign bus.lw_ready = ready;
  assign bus.count = cnt;

  // Write-port mux; reset drops the write immediately.
  always_comb begin
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    if (rst == RST_EN) begin
      bus.we = 1'b0;
    end else if (pipe_wr) begin
      bus.we = WR_EN;
      bus.waddr = bus.pipe_waddr;
      bus.wdata = bus.pipe_wdata;
    end else if (has && vld[rd_ptr]) begin
      bus.we = WR_EN;
      bus.waddr = addr_q[rd_ptr];
      bus.wdata = data_q[rd_ptr];
    end
  end

  // Queue state: kill stale entries, pop head, append late write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      vld <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && addr_q[i] == bus.pipe_waddr)
          vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= !lw_kill;
        addr_q[wr_ptr] <= bus.lw_waddr;
        data_q[wr_ptr] <= bus.lw_wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10: cnt <= cnt + 1'b1;
        2'b01: cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  wbq_match #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) u_match1 (
    .raddr(bus.raddr1),
    .rd_ptr(rd_ptr),
    .vld(vld),
    .addr(addr_q),
    .data(data_q),
    .hit(bus.hit1),
    .hdata(bus.hdata1)
  );

  wbq_match #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) u_match2 (
    .raddr(bus.raddr2),
    .rd_ptr(rd_ptr),
    .vld(vld),
    .addr(addr_q),
    .data(data_q),
    .hit(bus.hit2),
    .hdata(bus.hdata2)
  );
endmodule

// File: tb/tb_wb_write_buf.sv
// Bench for wb_write_buf: directed scenarios plus random traffic
// against a queue-level reference model.
module tb_wb_write_buf;
  import wb_write_buf_pkg::*;

  localparam int D = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = $clog2(D) + 1;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_write_buf_if #(.DEPTH(D), .AW(AW), .DW(DW)) bus();

  wb_write_buf #(.DEPTH(D), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  ent_t q[$];
  logic [DW-1:0] obs_rf [32];

  initial begin
    #300000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic idle();
    bus.pipe_we = 1'b0;
    bus.pipe_waddr = '0;
    bus.pipe_wdata = '0;
    bus.lw_valid = 1'b0;
    bus.lw_waddr = '0;
    bus.lw_wdata = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
  endtask

  task automatic model_step();
    bit pw;
    bit rdy;
    pw = bus.pipe_we && bus.pipe_waddr != 0;
    rdy = q.size() < D;
    if (rst) begin
      q.delete();
      return;
    end
    if (pw)
      foreach (q[i])
        if (q[i].a == bus.pipe_waddr) q[i].v = 1'b0;
    if (q.size() > 0 && !pw) void'(q.pop_front());
    if (bus.lw_valid && rdy && bus.lw_waddr != 0)
      q.push_back('{!(pw && bus.lw_waddr == bus.pipe_waddr),
                    bus.lw_waddr, bus.lw_wdata});
  endtask

  task automatic m_port(output logic w, output logic [AW-1:0] a,
                        output logic [DW-1:0] d);
    w = 1'b0; a = '0; d = '0;
    if (rst) return;
    if (bus.pipe_we && bus.pipe_waddr != 0) begin
      w = 1'b1; a = bus.pipe_waddr; d = bus.pipe_wdata;
    end else if (q.size() > 0 && q[0].v) begin
      w = 1'b1; a = q[0].a; d = q[0].d;
    end
  endtask

  task automatic m_hit(input logic [AW-1:0] ra, output logic h,
                       output logic [DW-1:0] hd);
    h = 1'b0; hd = '0;
    if (ra == 0) return;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].v && q[i].a == ra) begin
        h = 1'b1; hd = q[i].d;
        break;
      end
  endtask

  task automatic tick();
    if (bus.we === 1'b1) obs_rf[bus.waddr] = bus.wdata;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 16 && bus.count != 0; i++) begin
      #1;
      tick();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3;
    bus.pipe_wdata = 32'h33; bus.raddr1 = 5'd3;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++;
    if (bus.we !== 1'b0 || bus.count !== '0 ||
        bus.lw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: we=%b count=%0d rdy=%b want 0 0 0",
               bus.we, bus.count, bus.lw_ready);
    end
    n_cmp++;
    if (bus.hit1 !== 1'b0 || bus.hdata1 !== '0 ||
        bus.waddr !== '0 || bus.wdata !== '0) begin
      n_err++;
      $display("FAIL reset_bus: hit1=%b hdata1=%0h waddr=%0d wdata=%0h want 0",
               bus.hit1, bus.hdata1, bus.waddr, bus.wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (bus.lw_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: lw_ready=%b want 1", bus.lw_ready);
    end
  endtask

  task automatic test_drain();
    idle();
    bus.lw_valid = 1'b1; bus.lw_waddr = 5'd5;
    bus.lw_wdata = 32'h11111111;
    #1;
    n_cmp++;
    if (bus.we !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: we=%b want 0", bus.we);
    end
    tick();
    bus.lw_waddr = 5'd6; bus.lw_wdata = 32'h22222222;
    #1;
    n_cmp++;
    if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'h11111111}) begin
      n_err++;
      $display("FAIL drain_r5: got %b %0d %h want 1 5 11111111",
               bus.we, bus.waddr, bus.wdata);
    end
    tick();
    bus.lw_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd6, 32'h22222222}) begin
      n_err++;
      $display("FAIL drain_r6: got %b %0d %h want 1 6 22222222",
               bus.we, bus.waddr, bus.wdata);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.count !== '0 || bus.we !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done: count=%0d we=%b want 0 0",
               bus.count, bus.we);
    end
  endtask

  task automatic test_priority();
    idle();
    bus.lw_valid = 1'b1; bus.lw_waddr = 5'd7;
    bus.lw_wdata = 32'hAAAA0000;
    #1;
    tick();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h33;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 32'h33} ||
          bus.count !== CW'(1)) begin
        n_err++;
        $display("FAIL prio_pipe%0d: got %b %0d %h cnt=%0d want 1 3 33 cnt=1",
                 c, bus.we, bus.waddr, bus.wdata, bus.count);
      end
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 32'hAAAA0000}) begin
      n_err++;
      $display("FAIL prio_late: got %b %0d %h want 1 7 aaaa0000",
               bus.we, bus.waddr, bus.wdata);
    end
    tick();
  endtask

  task automatic test_kill();
    idle();
    bus.lw_valid = 1'b1; bus.lw_waddr = 5'd9; bus.lw_wdata = 32'h1;
    #1;
    tick();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd9; bus.pipe_wdata = 32'h2;
    bus.raddr1 = 5'd9;
    #1;
    n_cmp++;
    if ({bus.we, bus.waddr, bus.wdata, bus.hit1} !==
        {1'b1, 5'd9, 32'h2, 1'b1}) begin
      n_err++;
      $display("FAIL kill_pipe: got %b %0d %h hit=%b want 1 9 2 hit=1",
               bus.we, bus.waddr, bus.wdata, bus.hit1);
    end
    tick();
    bus.pipe_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.hit1 !== 1'b0 || bus.we !== 1'b0 || bus.count !== CW'(1)) begin
      n_err++;
      $display("FAIL kill_entry: hit1=%b we=%b count=%0d want 0 0 1",
               bus.hit1, bus.we, bus.count);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.count !== '0 || obs_rf[9] !== 32'h2) begin
      n_err++;
      $display("FAIL kill_final: count=%0d r9=%h want 0 2",
               bus.count, obs_rf[9]);
    end
  endtask

  task automatic test_full();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h5;
    bus.lw_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.lw_waddr = AW'(10 + k); bus.lw_wdata = DW'(32'hC0 + k);
      #1;
      tick();
    end
    bus.lw_waddr = 5'd14; bus.lw_wdata = 32'hE;
    #1;
    n_cmp++;
    if (bus.count !== CW'(4) || bus.lw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_state: count=%0d rdy=%b want 4 0",
               bus.count, bus.lw_ready);
    end
    tick();
    bus.pipe_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.count !== CW'(4) || bus.lw_ready !== 1'b0 ||
        bus.waddr !== 5'd10) begin
      n_err++;
      $display("FAIL full_pop: count=%0d rdy=%b waddr=%0d want 4 0 10",
               bus.count, bus.lw_ready, bus.waddr);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.count !== CW'(3) || bus.lw_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_reopen: count=%0d rdy=%b want 3 1",
               bus.count, bus.lw_ready);
    end
    tick();
    bus.lw_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.count !== CW'(3)) begin
      n_err++;
      $display("FAIL full_accept: count=%0d want 3", bus.count);
    end
    drain();
    n_cmp++;
    if (bus.count !== '0 || obs_rf[14] !== 32'hE ||
        obs_rf[13] !== 32'hC3) begin
      n_err++;
      $display("FAIL full_drain: count=%0d r14=%h r13=%h want 0 e c3",
               bus.count, obs_rf[14], obs_rf[13]);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h7;
    bus.lw_valid = 1'b1; bus.lw_waddr = 5'd4; bus.lw_wdata = 32'h10;
    #1;
    tick();
    bus.lw_wdata = 32'h20;
    #1;
    tick();
    bus.lw_valid = 1'b0;
    bus.raddr1 = 5'd4; bus.raddr2 = 5'd0;
    #1;
    n_cmp++;
    if (bus.hit1 !== 1'b1 || bus.hdata1 !== 32'h20) begin
      n_err++;
      $display("FAIL byp_young: hit1=%b hdata1=%h want 1 20",
               bus.hit1, bus.hdata1);
    end
    n_cmp++;
    if (bus.hit2 !== 1'b0 || bus.hdata2 !== '0) begin
      n_err++;
      $display("FAIL byp_r0: hit2=%b hdata2=%h want 0 0",
               bus.hit2, bus.hdata2);
    end
    bus.lw_valid = 1'b1; bus.lw_waddr = 5'd0; bus.lw_wdata = 32'h99;
    #1;
    n_cmp++;
    if (bus.lw_ready !== 1'b1) begin
      n_err++;
      $display("FAIL byp_r0_rdy: lw_ready=%b want 1", bus.lw_ready);
    end
    tick();
    bus.lw_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.count !== CW'(2)) begin
      n_err++;
      $display("FAIL byp_r0_cnt: count=%0d want 2", bus.count);
    end
    drain();
  endtask

  task automatic test_random();
    logic ew, eh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, ehd;
    for (int c = 0; c < 600; c++) begin
      bus.pipe_we = $urandom_range(0, 2) < (c < 300 ? 2 : 1);
      bus.pipe_waddr = AW'($urandom_range(0, 7));
      bus.pipe_wdata = $urandom;
      bus.lw_valid = $urandom_range(0, 1) == 1;
      bus.lw_waddr = AW'($urandom_range(0, 7));
      bus.lw_wdata = $urandom;
      bus.raddr1 = AW'($urandom_range(0, 7));
      bus.raddr2 = AW'($urandom_range(0, 7));
      #1;
      m_port(ew, ea, ed);
      n_cmp++;
      if ({bus.we, bus.waddr, bus.wdata} !== {ew, ea, ed}) begin
        n_err++;
        $display("FAIL rnd_port c=%0d: got %b %0d %h want %b %0d %h",
                 c, bus.we, bus.waddr, bus.wdata, ew, ea, ed);
      end
      n_cmp++;
      if (bus.count !== CW'(q.size()) ||
          bus.lw_ready !== (q.size() < D)) begin
        n_err++;
        $display("FAIL rnd_cnt c=%0d: count=%0d rdy=%b want %0d %b",
                 c, bus.count, bus.lw_ready, q.size(), q.size() < D);
      end
      m_hit(bus.raddr1, eh, ehd);
      n_cmp++;
      if (bus.hit1 !== eh || bus.hdata1 !== ehd) begin
        n_err++;
        $display("FAIL rnd_byp1 c=%0d: got %b %h want %b %h",
                 c, bus.hit1, bus.hdata1, eh, ehd);
      end
      m_hit(bus.raddr2, eh, ehd);
      n_cmp++;
      if (bus.hit2 !== eh || bus.hdata2 !== ehd) begin
        n_err++;
        $display("FAIL rnd_byp2 c=%0d: got %b %h want %b %h",
                 c, bus.hit2, bus.hdata2, eh, ehd);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h1;
    bus.lw_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.lw_waddr = AW'(20 + k); bus.lw_wdata = $urandom;
      #1;
      tick();
    end
    bus.lw_valid = 1'b0;
    bus.pipe_waddr = 5'd2;
    bus.raddr1 = 5'd20;
    #1;
    n_cmp++;
    if (bus.count !== CW'(3) || bus.hit1 !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: count=%0d hit1=%b want 3 1",
               bus.count, bus.hit1);
    end
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    n_cmp++;
    if (bus.we !== 1'b0 || bus.count !== '0 ||
        bus.lw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_now: we=%b count=%0d rdy=%b want 0 0 0",
               bus.we, bus.count, bus.lw_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.raddr1 = 5'd20;
    #1;
    n_cmp++;
    if (bus.lw_ready !== 1'b1 || bus.hit1 !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_after: rdy=%b hit1=%b want 1 0",
               bus.lw_ready, bus.hit1);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_priority();
    test_kill();
    test_full();
    test_bypass();
    test_random();
    drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
